fetch_unit: RTL and testbench

- Parametrised successor to the single-cycle PC register, +4 adder, branch adder and PC-select mux.
- Owns the program counter and drives the asynchronous-read instruction memory address.
- Buffers fetched {instruction, PC, PC+4} tuples in a FIFO of configurable depth.
- Hands tuples to decode over a valid/ready handshake. Supports redirect (taken branch/jump) with flush, back-pressure stall, and misaligned-target error trapping.

---
 rtl/fetch_if.sv | 27 ++
 rtl/fetch_unit.sv | 75 +++++++
 tb/tb_fetch_unit.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// fetch_if: instruction-memory, redirect and decode-handshake bundle of the fetch unit
interface fetch_if #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
);
    logic [DATA_WIDTH-1:0]         imem_addr;
    logic [DATA_WIDTH-1:0]         imem_rdata;
    logic                          redirect_valid;
    logic [DATA_WIDTH-1:0]         redirect_target;
    logic                          out_valid;
    logic                          out_ready;
    logic [DATA_WIDTH-1:0]         out_instr;
    logic [DATA_WIDTH-1:0]         out_pc;
    logic [DATA_WIDTH-1:0]         out_pc_plus4;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          fetch_err;

    modport master (
        output imem_addr, out_valid, out_instr, out_pc, out_pc_plus4, fifo_count, fetch_err,
        input  imem_rdata, redirect_valid, redirect_target, out_ready
    );

    modport slave (
        input  imem_addr, out_valid, out_instr, out_pc, out_pc_plus4, fifo_count, fetch_err,
        output imem_rdata, redirect_valid, redirect_target, out_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner with a fetch FIFO, redirect flush and misaligned-target trap
module fetch_unit #(
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter int                    FIFO_DEPTH   = 4
) (
    input logic     clk,
    input logic     rst,
    fetch_if.master bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
    localparam logic [DATA_WIDTH-1:0] STEP = DATA_WIDTH'(4);

    logic [DATA_WIDTH-1:0] pc;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  err;
    logic                  push;
    logic                  pop;
    logic                  misaligned;
    logic [DATA_WIDTH-1:0] instr_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] pc_q    [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] pc4_q   [FIFO_DEPTH];

    assign bus.imem_addr    = pc;
    assign bus.out_valid    = (count != '0) & ~bus.redirect_valid;
    assign bus.out_instr    = instr_q[rd_ptr];
    assign bus.out_pc       = pc_q[rd_ptr];
    assign bus.out_pc_plus4 = pc4_q[rd_ptr];
    assign bus.fifo_count   = count;
    assign bus.fetch_err    = err;

    // handshake: a redirect cycle never transfers; a full FIFO may push when it pops
    always_comb begin
        pop        = bus.out_valid & bus.out_ready;
        push       = ~bus.redirect_valid & ~err & ((count < FULL) | pop);
        misaligned = bus.redirect_target[1:0] != 2'b00;
    end

    // pc, pointers, occupancy and sticky error; redirect flushes and outranks push/pop
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc     <= RESET_VECTOR;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err    <= 1'b0;
        end else if (bus.redirect_valid) begin
            pc     <= {bus.redirect_target[DATA_WIDTH-1:2], 2'b00};
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err    <= misaligned;
        end else begin
            if (push) begin
                pc     <= pc + STEP;
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // tuple storage needs no reset; empty entries are never presented as valid
    always_ff @(posedge clk) begin
        if (push) begin
            instr_q[wr_ptr] <= bus.imem_rdata;
            pc_q[wr_ptr]    <= pc;
            pc4_q[wr_ptr]   <= pc + STEP;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random stimulus against a queue-based fetch model
module tb_fetch_unit;
    localparam logic [31:0] XOR_PAT = 32'hA5A5_0000;
    localparam logic [31:0] RV2     = 32'hFFFF_FFF8;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    ent_t        q[$];
    logic [31:0] m_pc;
    logic        m_err;
    logic        w_on;
    int          w_n;

    fetch_if #(.DATA_WIDTH(32), .FIFO_DEPTH(4)) b1 ();
    fetch_if #(.DATA_WIDTH(32), .FIFO_DEPTH(4)) b2 ();

    assign b1.imem_rdata = b1.imem_addr ^ XOR_PAT;
    assign b2.imem_rdata = b2.imem_addr ^ XOR_PAT;

    fetch_unit #(.DATA_WIDTH(32), .RESET_VECTOR(32'h0), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .bus(b1.master)
    );

    fetch_unit #(.DATA_WIDTH(32), .RESET_VECTOR(RV2), .FIFO_DEPTH(4)) dut_wrap (
        .clk(clk), .rst(rst), .bus(b2.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic r, input logic rv, input logic [31:0] t, input logic rdy);
        logic ev;
        logic pp;
        logic ps;
        int   sz;
        @(negedge clk);
        rst = r;
        b1.redirect_valid = rv; b1.redirect_target = t; b1.out_ready = rdy;
        b2.redirect_valid = rv; b2.redirect_target = t; b2.out_ready = rdy;
        #1;
        sz = q.size();
        ev = (sz != 0) && !rv;
        chk("out_valid", {31'b0, b1.out_valid}, {31'b0, ev});
        chk("fifo_count", 32'(b1.fifo_count), 32'(sz));
        chk("fetch_err", {31'b0, b1.fetch_err}, {31'b0, m_err});
        chk("imem_addr", b1.imem_addr, m_pc);
        if (ev) begin
            chk("out_pc", b1.out_pc, q[0].pc);
            chk("out_instr", b1.out_instr, q[0].instr);
            chk("out_pc_plus4", b1.out_pc_plus4, q[0].pc + 32'd4);
        end
        if (w_on) begin
            chk("wrap_valid", {31'b0, b2.out_valid}, {31'b0, w_n >= 1});
            chk("wrap_addr", b2.imem_addr, RV2 + 32'(4 * w_n));
            if (w_n >= 1) chk("wrap_pc", b2.out_pc, RV2 + 32'(4 * (w_n - 1)));
            w_n++;
        end
        if (!r) begin
            q.delete();
            m_pc  = 32'h0;
            m_err = 1'b0;
        end else if (rv) begin
            q.delete();
            m_pc  = {t[31:2], 2'b00};
            m_err = t[1:0] != 2'b00;
        end else begin
            pp = ev && rdy;
            ps = !m_err && (sz < 4 || pp);
            if (pp) void'(q.pop_front());
            if (ps) begin
                q.push_back('{instr: m_pc ^ XOR_PAT, pc: m_pc});
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk);
    endtask

    initial begin
        logic [31:0] t;
        checks = 0;
        errors = 0;
        w_on   = 1'b0;
        w_n    = 0;
        rst    = 1'b0;
        b1.redirect_valid = 1'b0; b1.redirect_target = '0; b1.out_ready = 1'b0;
        b2.redirect_valid = 1'b0; b2.redirect_target = '0; b2.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        m_pc  = 32'h0;
        m_err = 1'b0;
        q.delete();
        repeat (6) cycle(1'b1, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        repeat (10) cycle(1'b1, 1'b0, 32'h0, 1'b0);
        repeat (8) cycle(1'b1, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        repeat (3) cycle(1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 1'b1, 32'h100, 1'b1);
        repeat (4) cycle(1'b1, 1'b0, 32'h0, 1'b1);
        cycle(1'b1, 1'b1, 32'h202, 1'b1);
        repeat (5) cycle(1'b1, 1'b0, 32'h0, 1'b1);
        cycle(1'b1, 1'b1, 32'h300, 1'b1);
        repeat (4) cycle(1'b1, 1'b0, 32'h0, 1'b1);
        repeat (5) cycle(1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 1'b1, 32'h203, 1'b0);
        repeat (2) cycle(1'b1, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b1, 32'h400, 1'b1);
        repeat (3) cycle(1'b1, 1'b0, 32'h0, 1'b1);
        cycle(1'b1, 1'b1, 32'hFFFF_FFF0, 1'b1);
        repeat (8) cycle(1'b1, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 500; i++) begin
            t = $urandom();
            if ($urandom_range(0, 3) == 0) t = {28'hFFFF_FFF, t[3:0]};
            if ($urandom_range(0, 2) != 0) t[1:0] = 2'b00;
            cycle($urandom_range(0, 49) != 0, $urandom_range(0, 7) == 0, t, $urandom_range(0, 2) != 0);
        end
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        w_on = 1'b1;
        w_n  = 0;
        repeat (6) cycle(1'b1, 1'b0, 32'h0, 1'b1);
        w_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
